// File: rtl/elevator_pkg.sv
// elevator_pkg: shared state, floor, button and countdown constants for the two-floor elevator
package elevator_pkg;
  localparam int STATE_W = 3;
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE       = 3'd0,
    ST_FLOOR1     = 3'd1,
    ST_FLOOR2     = 3'd2,
    ST_GOING_TO_1 = 3'd3,
    ST_GOING_TO_2 = 3'd4
  } state_t;
  localparam logic FLOOR_1 = 1'b0;
  localparam logic FLOOR_2 = 1'b1;
  localparam int BTN_F1 = 0;
  localparam int BTN_F2 = 1;
  localparam int BTN_HOLD = 2;
  localparam logic [2:0] CNT_DONE = 3'd0;
endpackage

// File: rtl/elevator_if.sv
// elevator_if: button/countdown inputs and state/door/motor outputs of the elevator sequencer
//   btn_shot[2:0] one-shot calls (floor1, floor2, hold); cnt_value[2:0] countdown 5..0
//   state, cur_floor, req_pending[1:0], door_open, motor_up, motor_down driven by the sequencer
interface elevator_if;
  import elevator_pkg::*;
  logic [2:0] btn_shot;
  logic [2:0] cnt_value;
  logic [STATE_W-1:0] state;
  logic cur_floor;
  logic [1:0] req_pending;
  logic door_open;
  logic motor_up;
  logic motor_down;
  modport master (output btn_shot, cnt_value, input state, cur_floor, req_pending, door_open, motor_up, motor_down);
  modport slave (input btn_shot, cnt_value, output state, cur_floor, req_pending, door_open, motor_up, motor_down);
endinterface

// File: rtl/elevator_req_latch.sv
// elevator_req_latch: holds the two floor-call bits; a bit cleared by arrival on the same edge stays cleared
//   clk, rst; btn[1:0] floor-call shots; state current FSM state; auto_set forces a floor1 call;
//   clr[1:0] arrival clear per floor; flush clears both; req[1:0] latched calls
module elevator_req_latch
  import elevator_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] btn,
  input  state_t     state,
  input  logic       auto_set,
  input  logic [1:0] clr,
  input  logic       flush,
  output logic [1:0] req
);
  logic [1:0] set;
  // only the floor the car is not at (or not heading to) can be called
  assign set = {btn[BTN_F2] && (state == ST_FLOOR1 || state == ST_GOING_TO_1),
                (btn[BTN_F1] && (state == ST_FLOOR2 || state == ST_GOING_TO_2)) || auto_set};
  always_ff @(posedge clk)
    if (rst || flush) req <= 2'b00;
    else req <= (req | set) & ~clr;
endmodule

// File: rtl/elevator_ctrl.sv
// elevator_ctrl: two-floor elevator sequencer driving door/motors from the 5 s countdown value
//   clk 10 kHz; rst synchronous active-high; bus (elevator_if.slave) carries buttons, countdown and outputs
//   HOME_FLOOR selects the floor entered after reset
//   define ELEV_AUTO_RETURN_EN to send an idle car at floor2 back to floor1
module elevator_ctrl
  import elevator_pkg::*;
#(
  parameter logic HOME_FLOOR = 1'b0
) (
  input logic       clk,
  input logic       rst,
  elevator_if.slave bus
);
  state_t state_q, state_d;
  logic floor_q, floor_d, armed_q, armed_d;
  logic done, block, tgt, arrive, auto_set, flush;
  logic [1:0] req;
  assign done = bus.cnt_value == CNT_DONE;
  // a shot that restarts the countdown must also hold the car at the floor this cycle
  assign block = (state_q == ST_FLOOR1 && (bus.btn_shot[BTN_HOLD] || bus.btn_shot[BTN_F2])) ||
                 (state_q == ST_FLOOR2 && (bus.btn_shot[BTN_HOLD] || bus.btn_shot[BTN_F1]));
  assign tgt = state_q == ST_GOING_TO_2 ? FLOOR_2 : FLOOR_1;
  assign flush = state_q > ST_GOING_TO_2;
  always_comb begin
    state_d = state_q;
    floor_d = floor_q;
    armed_d = 1'b0;
    arrive = 1'b0;
    auto_set = 1'b0;
    case (state_q)
      ST_IDLE: state_d = floor_q ? ST_FLOOR2 : ST_FLOOR1;
      ST_FLOOR1: state_d = done && req[FLOOR_2] && !block ? ST_GOING_TO_2 : ST_FLOOR1;
      ST_FLOOR2: begin
        state_d = done && req[FLOOR_1] && !block ? ST_GOING_TO_1 : ST_FLOOR2;
`ifdef ELEV_AUTO_RETURN_EN
        auto_set = done && req == 2'b00 && bus.btn_shot == 3'b000;
`endif
      end
      ST_GOING_TO_1, ST_GOING_TO_2: begin
        // the counter is still 0 on entry; only a 0 after a running count means arrival
        arrive = done && armed_q;
        armed_d = !arrive && (armed_q || !done);
        state_d = arrive ? (tgt ? ST_FLOOR2 : ST_FLOOR1) : state_q;
        floor_d = arrive ? tgt : floor_q;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= ST_IDLE;
      floor_q <= HOME_FLOOR;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      floor_q <= floor_d;
      armed_q <= armed_d;
    end
  elevator_req_latch u_req (
    .clk(clk),
    .rst(rst),
    .btn(bus.btn_shot[1:0]),
    .state(state_q),
    .auto_set(auto_set),
    .clr({arrive && tgt, arrive && !tgt}),
    .flush(flush),
    .req(req)
  );
  assign bus.state = state_q;
  assign bus.cur_floor = floor_q;
  assign bus.req_pending = req;
  assign bus.door_open = (state_q == ST_FLOOR1 || state_q == ST_FLOOR2) && !done;
  assign bus.motor_up = state_q == ST_GOING_TO_2;
  assign bus.motor_down = state_q == ST_GOING_TO_1;
endmodule

// File: tb/tb_elevator_ctrl.sv
// tb_elevator_ctrl: directed check of elevator_ctrl with the countdown value driven as a short scaled sequence
module tb_elevator_ctrl;
  import elevator_pkg::*;
`ifdef ELEV_AUTO_RETURN_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int passed = 0;
  int fails = 0;
  elevator_if bus();
  elevator_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input logic [2:0] b, input logic [2:0] c);
    bus.btn_shot = b;
    bus.cnt_value = c;
    @(posedge clk);
    #1;
    bus.btn_shot = 3'b000;
  endtask
  initial begin
    bus.btn_shot = 3'b000;
    bus.cnt_value = 3'd5;
    cyc(3'b000, 3'd5);
    cyc(3'b000, 3'd5);
    chk("rst_state", bus.state, 8'd0);
    chk("rst_floor", bus.cur_floor, 8'd0);
    chk("rst_req", bus.req_pending, 8'd0);
    chk("rst_door", bus.door_open, 8'd0);
    chk("rst_motors", {bus.motor_up, bus.motor_down}, 8'd0);
    rst = 1'b0;
    cyc(3'b000, 3'd5);
    chk("idle_to_f1", bus.state, 8'd1);
    chk("f1_door_open", bus.door_open, 8'd1);
    cyc(3'b000, 3'd0);
    chk("f1_parked", bus.state, 8'd1);
    chk("f1_door_closed", bus.door_open, 8'd0);
    cyc(3'b010, 3'd0);
    chk("call_f2_req", bus.req_pending, 8'd2);
    chk("call_f2_blocked", bus.state, 8'd1);
    cyc(3'b000, 3'd5);
    chk("f1_reopen", bus.door_open, 8'd1);
    cyc(3'b000, 3'd3);
    cyc(3'b000, 3'd1);
    chk("f1_dwell", bus.state, 8'd1);
    cyc(3'b000, 3'd0);
    chk("depart_up", bus.state, 8'd4);
    chk("motor_up", {bus.motor_up, bus.motor_down}, 8'd2);
    chk("door_travel", bus.door_open, 8'd0);
    cyc(3'b000, 3'd0);
    chk("no_early_arrive", bus.state, 8'd4);
    cyc(3'b000, 3'd5);
    cyc(3'b001, 3'd3);
    chk("travel_call_f1", bus.req_pending, 8'd3);
    cyc(3'b010, 3'd2);
    cyc(3'b100, 3'd1);
    chk("travel_ignore", bus.req_pending, 8'd3);
    chk("still_up", bus.state, 8'd4);
    cyc(3'b000, 3'd0);
    chk("arrive_f2", bus.state, 8'd2);
    chk("arrive_f2_floor", bus.cur_floor, 8'd1);
    chk("arrive_f2_req", bus.req_pending, 8'd1);
    cyc(3'b000, 3'd5);
    chk("f2_door", bus.door_open, 8'd1);
    cyc(3'b100, 3'd0);
    chk("hold_blocks", bus.state, 8'd2);
    cyc(3'b000, 3'd5);
    cyc(3'b000, 3'd0);
    chk("depart_down", bus.state, 8'd3);
    chk("motor_down", {bus.motor_up, bus.motor_down}, 8'd1);
    cyc(3'b000, 3'd0);
    cyc(3'b000, 3'd4);
    cyc(3'b000, 3'd0);
    chk("arrive_f1", bus.state, 8'd1);
    chk("arrive_f1_floor", bus.cur_floor, 8'd0);
    chk("arrive_f1_req", bus.req_pending, 8'd0);
    cyc(3'b000, 3'd5);
    cyc(3'b010, 3'd0);
    chk("shot_at_expiry", bus.state, 8'd1);
    cyc(3'b000, 3'd5);
    chk("restart_dwell", bus.state, 8'd1);
    cyc(3'b000, 3'd0);
    chk("late_depart", bus.state, 8'd4);
    cyc(3'b000, 3'd0);
    cyc(3'b000, 3'd5);
    cyc(3'b011, 3'd0);
    chk("clear_wins_state", bus.state, 8'd2);
    chk("clear_wins_req", bus.req_pending, 8'd1);
    cyc(3'b000, 3'd5);
    cyc(3'b000, 3'd0);
    cyc(3'b000, 3'd0);
    cyc(3'b000, 3'd4);
    cyc(3'b000, 3'd0);
    chk("back_f1", bus.state, 8'd1);
    cyc(3'b011, 3'd0);
    chk("both_req", bus.req_pending, 8'd2);
    chk("both_blocked", bus.state, 8'd1);
    cyc(3'b000, 3'd5);
    cyc(3'b000, 3'd0);
    cyc(3'b000, 3'd0);
    cyc(3'b000, 3'd3);
    chk("mid_travel", bus.state, 8'd4);
    rst = 1'b1;
    cyc(3'b000, 3'd3);
    rst = 1'b0;
    chk("midrst_state", bus.state, 8'd0);
    chk("midrst_floor", bus.cur_floor, 8'd0);
    chk("midrst_req", bus.req_pending, 8'd0);
    chk("midrst_motors", {bus.motor_up, bus.motor_down}, 8'd0);
    cyc(3'b000, 3'd5);
    cyc(3'b010, 3'd0);
    chk("pre_illegal_req", bus.req_pending, 8'd2);
    dut.state_q = state_t'(3'd6);
    #1;
    chk("illegal_outputs", {bus.door_open, bus.motor_up, bus.motor_down}, 8'd0);
    cyc(3'b000, 3'd5);
    chk("illegal_to_idle", bus.state, 8'd0);
    chk("illegal_req_clr", bus.req_pending, 8'd0);
    cyc(3'b000, 3'd5);
    chk("idle_again_f1", bus.state, 8'd1);
    cyc(3'b010, 3'd0);
    cyc(3'b000, 3'd5);
    cyc(3'b000, 3'd0);
    cyc(3'b000, 3'd0);
    cyc(3'b000, 3'd2);
    cyc(3'b000, 3'd0);
    chk("park_f2", bus.state, 8'd2);
    cyc(3'b000, 3'd5);
    cyc(3'b000, 3'd0);
    chk("auto_req", bus.req_pending, AUTO ? 8'd1 : 8'd0);
    chk("auto_hold", bus.state, 8'd2);
    cyc(3'b000, 3'd0);
    chk("auto_leave", bus.state, AUTO ? 8'd3 : 8'd2);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
